hazard_ctrl: RTL and testbench

Pipeline hazard unit for the five-stage MIPS core. It sits directly downstream of the D-stage instruction classifier and consumes that classifier's class flags (B, CAL_R, CAL_I, LOAD, STORE, JAL, JR, JALR) plus the D-stage instruction word. It keeps its own shadow pipeline of in-flight destination/Tnew records for E, M and W. From that it drives the D-stage stall and all forwarding-mux selects.

---
 rtl/hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: D-stage stall and forwarding-select generation for the five-stage MIPS core.
// A shadow pipeline of {dst, tnew, rs, rt} records for E/M/W is fed from the D-stage class flags.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_ir,
  input  logic        d_b,
  input  logic        d_cal_r,
  input  logic        d_cal_i,
  input  logic        d_load,
  input  logic        d_store,
  input  logic        d_jal,
  input  logic        d_jr,
  input  logic        d_jalr,
  output logic        stall,
  output logic [1:0]  fwd_d_rs,
  output logic [1:0]  fwd_d_rt,
  output logic [1:0]  fwd_e_rs,
  output logic [1:0]  fwd_e_rt,
  output logic        fwd_m_rt
);

  logic       use_rs_s, use_rt_s;
  logic [1:0] tuse_rs_s, tuse_rt_s, d_tnew_s;
  logic [4:0] d_rs_s, d_rt_s, d_dst_s;

  logic [4:0] e_dst_r, e_rs_r, e_rt_r, m_dst_r, m_rt_r, w_dst_r;
  logic [1:0] e_tnew_r, m_tnew_r, w_tnew_r;
  logic       unused_s;

  function automatic logic hit(input logic [4:0] a, input logic [4:0] dst);
    return (a != 5'd0) && (a == dst);
  endfunction

  function automatic logic [1:0] dec_sat(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // The newest matching stage decides: an E hit masks whatever M holds for the same register.
  function automatic logic op_stall(input logic [4:0] a, input logic [1:0] tuse,
                                    input logic [4:0] e_dst, input logic [1:0] e_tnew,
                                    input logic [4:0] m_dst, input logic [1:0] m_tnew);
    if (hit(a, e_dst)) begin
      return e_tnew > tuse;
    end else begin
      return hit(a, m_dst) && (m_tnew > tuse);
    end
  endfunction

  function automatic logic [1:0] fwd_d_sel(input logic [4:0] a,
                                           input logic [4:0] e_dst, input logic [1:0] e_tnew,
                                           input logic [4:0] m_dst, input logic [1:0] m_tnew);
    if (hit(a, e_dst) && (e_tnew == 2'd0)) begin
      return 2'd1;
    end else if (hit(a, m_dst) && (m_tnew == 2'd0)) begin
      return 2'd2;
    end else begin
      return 2'd0;
    end
  endfunction

  function automatic logic [1:0] fwd_e_sel(input logic [4:0] a,
                                           input logic [4:0] m_dst, input logic [1:0] m_tnew,
                                           input logic [4:0] w_dst, input logic [1:0] w_tnew);
    if (hit(a, m_dst) && (m_tnew == 2'd0)) begin
      return 2'd1;
    end else if (hit(a, w_dst) && (w_tnew == 2'd0)) begin
      return 2'd2;
    end else begin
      return 2'd0;
    end
  endfunction

  // D-stage decode: operand usage, Tuse, destination and Tnew of the instruction in D
  always_comb begin
    use_rs_s  = d_b | d_jr | d_jalr | d_cal_r | d_cal_i | d_load | d_store;
    use_rt_s  = d_b | d_cal_r | d_store;
    tuse_rs_s = (d_b | d_jr | d_jalr) ? 2'd0 : 2'd1;
    if (d_b) begin
      tuse_rt_s = 2'd0;
    end else if (d_cal_r) begin
      tuse_rt_s = 2'd1;
    end else begin
      tuse_rt_s = 2'd2;
    end
    if (d_cal_r | d_jalr) begin
      d_dst_s = d_ir[15:11];
    end else if (d_cal_i | d_load) begin
      d_dst_s = d_ir[20:16];
    end else if (d_jal) begin
      d_dst_s = 5'd31;
    end else begin
      d_dst_s = 5'd0;
    end
    if (d_load) begin
      d_tnew_s = 2'd2;
    end else if (d_cal_r | d_cal_i) begin
      d_tnew_s = 2'd1;
    end else begin
      d_tnew_s = 2'd0;
    end
    // Unused operands carry address 0 so they can never hit downstream.
    d_rs_s = use_rs_s ? d_ir[25:21] : 5'd0;
    d_rt_s = use_rt_s ? d_ir[20:16] : 5'd0;
  end

  assign stall = op_stall(d_rs_s, tuse_rs_s, e_dst_r, e_tnew_r, m_dst_r, m_tnew_r)
               | op_stall(d_rt_s, tuse_rt_s, e_dst_r, e_tnew_r, m_dst_r, m_tnew_r);

  assign fwd_d_rs = fwd_d_sel(d_rs_s, e_dst_r, e_tnew_r, m_dst_r, m_tnew_r);
  assign fwd_d_rt = fwd_d_sel(d_rt_s, e_dst_r, e_tnew_r, m_dst_r, m_tnew_r);
  assign fwd_e_rs = fwd_e_sel(e_rs_r, m_dst_r, m_tnew_r, w_dst_r, w_tnew_r);
  assign fwd_e_rt = fwd_e_sel(e_rt_r, m_dst_r, m_tnew_r, w_dst_r, w_tnew_r);
  assign fwd_m_rt = hit(m_rt_r, w_dst_r);

  assign unused_s = &{1'b0, d_ir[31:26], d_ir[10:0]};

  // Shadow pipeline: E takes the D record (or a bubble on stall), M and W age by one stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_dst_r  <= 5'd0;
      e_rs_r   <= 5'd0;
      e_rt_r   <= 5'd0;
      e_tnew_r <= 2'd0;
      m_dst_r  <= 5'd0;
      m_rt_r   <= 5'd0;
      m_tnew_r <= 2'd0;
      w_dst_r  <= 5'd0;
      w_tnew_r <= 2'd0;
    end else begin
      if (stall) begin
        e_dst_r  <= 5'd0;
        e_rs_r   <= 5'd0;
        e_rt_r   <= 5'd0;
        e_tnew_r <= 2'd0;
      end else begin
        e_dst_r  <= d_dst_s;
        e_rs_r   <= d_rs_s;
        e_rt_r   <= d_rt_s;
        e_tnew_r <= d_tnew_s;
      end
      m_dst_r  <= e_dst_r;
      m_rt_r   <= e_rt_r;
      m_tnew_r <= dec_sat(e_tnew_r);
      w_dst_r  <= m_dst_r;
      w_tnew_r <= dec_sat(m_tnew_r);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios plus randomized instruction
// streams, compared against a ready-time model of the in-flight E/M/W instructions.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] d_ir;
  logic        d_b, d_cal_r, d_cal_i, d_load, d_store, d_jal, d_jr, d_jalr;
  logic        stall;
  logic [1:0]  fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
  logic        fwd_m_rt;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .d_ir(d_ir),
    .d_b(d_b), .d_cal_r(d_cal_r), .d_cal_i(d_cal_i), .d_load(d_load),
    .d_store(d_store), .d_jal(d_jal), .d_jr(d_jr), .d_jalr(d_jalr),
    .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt)
  );

  // Classes: 0 nop, 1 B, 2 CAL_R, 3 CAL_I, 4 LOAD, 5 STORE, 6 JAL, 7 JR, 8 JALR
  localparam int NOP = 0, BR = 1, CALR = 2, CALI = 3, LD = 4, ST = 5, JAL = 6, JR = 7, JALR = 8;
  int tuse_rs_tab [9] = '{-1, 0, 1, 1, 1, 1, -1, 0, 0};
  int tuse_rt_tab [9] = '{-1, 0, 1, -1, -1, 2, -1, -1, -1};
  int tnew_tab    [9] = '{0, 0, 1, 1, 2, 0, 0, 0, 0};

  // In-flight instruction: result becomes available at absolute cycle 'ready'.
  typedef struct {
    logic [4:0] dst;
    logic [4:0] rs;
    logic [4:0] rt;
    int         ready;
  } rec_t;

  rec_t st [3];   // 0 = E, 1 = M, 2 = W
  int   now_c;
  int   n_vec;
  int   n_mis;
  logic exp_stall_last;
  logic obs_stall, obs_fwd_m_rt;
  logic [1:0] obs_fwd_d_rs, obs_fwd_d_rt, obs_fwd_e_rs, obs_fwd_e_rt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int rem(input int s);
    return (st[s].ready > now_c) ? st[s].ready - now_c : 0;
  endfunction

  function automatic logic hits(input logic [4:0] a, input int s);
    return (a != 5'd0) && (a == st[s].dst);
  endfunction

  function automatic logic m_stall(input logic [4:0] a, input int tuse);
    if (tuse < 0) return 1'b0;
    if (hits(a, 0)) return rem(0) > tuse;
    return hits(a, 1) && (rem(1) > tuse);
  endfunction

  function automatic logic [1:0] m_fwd_d(input logic [4:0] a, input int tuse);
    if (tuse < 0) return 2'd0;
    if (hits(a, 0) && rem(0) == 0) return 2'd1;
    if (hits(a, 1) && rem(1) == 0) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [1:0] m_fwd_e(input logic [4:0] a);
    if (hits(a, 1) && rem(1) == 0) return 2'd1;
    if (hits(a, 2)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [4:0] dst_of(input int cls, input logic [31:0] ir);
    case (cls)
      CALR, JALR: return ir[15:11];
      CALI, LD:   return ir[20:16];
      JAL:        return 5'd31;
      default:    return 5'd0;
    endcase
  endfunction

  task automatic drive(input int cls, input logic [31:0] ir);
    d_ir = ir;
    d_b = (cls == BR); d_cal_r = (cls == CALR); d_cal_i = (cls == CALI); d_load = (cls == LD);
    d_store = (cls == ST); d_jal = (cls == JAL); d_jr = (cls == JR); d_jalr = (cls == JALR);
  endtask

  // Called at a negedge: drive D, compare all outputs, advance model across the next posedge.
  task automatic apply(input int cls, input logic [31:0] ir);
    logic [4:0] rs, rt;
    int trs, trt;
    logic es;
    drive(cls, ir);
    #1;
    rs = ir[25:21];
    rt = ir[20:16];
    trs = tuse_rs_tab[cls];
    trt = tuse_rt_tab[cls];
    es = m_stall(rs, trs) | m_stall(rt, trt);
    check_eq("stall", {31'd0, stall}, {31'd0, es});
    check_eq("fwd_d_rs", {30'd0, fwd_d_rs}, {30'd0, m_fwd_d(rs, trs)});
    check_eq("fwd_d_rt", {30'd0, fwd_d_rt}, {30'd0, m_fwd_d(rt, trt)});
    check_eq("fwd_e_rs", {30'd0, fwd_e_rs}, {30'd0, m_fwd_e(st[0].rs)});
    check_eq("fwd_e_rt", {30'd0, fwd_e_rt}, {30'd0, m_fwd_e(st[0].rt)});
    check_eq("fwd_m_rt", {31'd0, fwd_m_rt}, {31'd0, hits(st[1].rt, 2)});
    obs_stall = stall; obs_fwd_d_rs = fwd_d_rs; obs_fwd_d_rt = fwd_d_rt;
    obs_fwd_e_rs = fwd_e_rs; obs_fwd_e_rt = fwd_e_rt; obs_fwd_m_rt = fwd_m_rt;
    exp_stall_last = es;
    @(posedge clk);
    now_c++;
    st[2] = st[1];
    st[1] = st[0];
    if (es) st[0] = '{5'd0, 5'd0, 5'd0, 0};
    else st[0] = '{dst_of(cls, ir), (trs >= 0) ? rs : 5'd0, (trt >= 0) ? rt : 5'd0,
                   now_c + tnew_tab[cls]};
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {26'd0, stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt}, 32'd0);
  endtask

  // Called at a negedge with D already driven: async reset mid-cycle, held over one edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1 check_all_zero("rst_async");
    @(posedge clk);
    #1 check_all_zero("rst_held");
    @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 3; s++) st[s] = '{5'd0, 5'd0, 5'd0, 0};
    exp_stall_last = 1'b0;
  endtask

  task automatic flush();
    repeat (3) apply(NOP, 32'h0);
  endtask

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 5'd31 : r[4:0];
  endfunction

  localparam logic [31:0] LW8    = 32'h8D280000;  // lw   $8,0($9)
  localparam logic [31:0] ADDU10 = 32'h01085021;  // addu $10,$8,$8
  localparam logic [31:0] BEQ8   = 32'h11000000;  // beq  $8,$0
  localparam logic [31:0] BEQ10  = 32'h11400000;  // beq  $10,$0
  localparam logic [31:0] JALI   = 32'h0C000000;  // jal
  localparam logic [31:0] JR31   = 32'h03E00008;  // jr   $31
  localparam logic [31:0] ADDU0  = 32'h00220021;  // addu $0,$1,$2
  localparam logic [31:0] BEQ00  = 32'h10000000;  // beq  $0,$0
  localparam logic [31:0] LW5    = 32'h8CC50000;  // lw   $5,0($6)
  localparam logic [31:0] SW5    = 32'hACC50000;  // sw   $5,0($6)

  initial begin
    int cls;
    logic [31:0] ir;
    n_vec = 0; n_mis = 0; now_c = 0; exp_stall_last = 1'b0;
    for (int s = 0; s < 3; s++) st[s] = '{5'd0, 5'd0, 5'd0, 0};
    reset = 1'b1;
    drive(NOP, 32'h0);
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;

    // Load-use
    apply(LD, LW8);
    apply(CALR, ADDU10); check_eq("lu_c1_stall", {31'd0, obs_stall}, 32'd1);
    apply(CALR, ADDU10); check_eq("lu_c2_stall", {31'd0, obs_stall}, 32'd0);
    apply(NOP, 32'h0);
    check_eq("lu_c3_fwd_e_rs", {30'd0, obs_fwd_e_rs}, 32'd2);
    check_eq("lu_c3_fwd_e_rt", {30'd0, obs_fwd_e_rt}, 32'd2);
    flush();

    // Load-branch: two stall cycles, then register file (load in W)
    apply(LD, LW8);
    apply(BR, BEQ8); check_eq("lb_c1_stall", {31'd0, obs_stall}, 32'd1);
    apply(BR, BEQ8); check_eq("lb_c2_stall", {31'd0, obs_stall}, 32'd1);
    apply(BR, BEQ8); check_eq("lb_c3_stall", {31'd0, obs_stall}, 32'd0);
    check_eq("lb_c3_fwd_d_rs", {30'd0, obs_fwd_d_rs}, 32'd0);
    flush();

    // ALU-branch
    apply(CALR, ADDU10);
    apply(BR, BEQ10); check_eq("ab_c1_stall", {31'd0, obs_stall}, 32'd1);
    apply(BR, BEQ10); check_eq("ab_c2_stall", {31'd0, obs_stall}, 32'd0);
    check_eq("ab_c2_fwd_d_rs", {30'd0, obs_fwd_d_rs}, 32'd2);
    flush();

    // Link forwarding from E, then from M
    apply(JAL, JALI);
    apply(JR, JR31);
    check_eq("jal_e_stall", {31'd0, obs_stall}, 32'd0);
    check_eq("jal_e_fwd_d_rs", {30'd0, obs_fwd_d_rs}, 32'd1);
    flush();
    apply(JAL, JALI);
    apply(NOP, 32'h0);
    apply(JR, JR31);
    check_eq("jal_m_fwd_d_rs", {30'd0, obs_fwd_d_rs}, 32'd2);
    flush();

    // $0 never hazards
    apply(CALR, ADDU0);
    apply(BR, BEQ00);
    check_eq("r0_stall", {31'd0, obs_stall}, 32'd0);
    check_eq("r0_fwd_d", {28'd0, obs_fwd_d_rs, obs_fwd_d_rt}, 32'd0);
    flush();

    // Store data forwarded from W into M
    apply(LD, LW5);
    apply(ST, SW5); check_eq("st_stall", {31'd0, obs_stall}, 32'd0);
    apply(NOP, 32'h0);
    apply(NOP, 32'h0);
    check_eq("st_fwd_m_rt", {31'd0, obs_fwd_m_rt}, 32'd1);
    flush();

    // Reset in the middle of a load-use stall, then no residual stall
    apply(LD, LW8);
    drive(CALR, ADDU10);
    do_reset();
    apply(CALR, ADDU10);
    check_eq("post_rst_stall", {31'd0, obs_stall}, 32'd0);
    flush();

    // Randomized stream; stalled instructions are held as the upstream freeze would
    cls = NOP;
    ir = 32'h0;
    for (int i = 0; i < 600; i++) begin
      if (!exp_stall_last) begin
        cls = $urandom_range(0, 8);
        ir = $urandom;
        ir[25:21] = pick_reg();
        ir[20:16] = pick_reg();
        ir[15:11] = pick_reg();
      end
      if ($urandom_range(0, 79) == 0) begin
        drive(cls, ir);
        do_reset();
      end
      apply(cls, ir);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
